dm_cache: RTL

Direct-mapped, write-back, write-allocate cache between the multicycle CPU memory port and 256-bit-line physical memory. It accepts the CPU's word-level read/write requests, answers hits from local arrays, and services misses by writing back a dirty victim and fetching the full line. The CPU-side handshake is unchanged: the request is held until the one-cycle `mem_resp`.

---
 rtl/dm_cache.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dm_cache.sv
// ----------------------------------------------------------------------------
// dm_cache : direct-mapped, write-back, write-allocate cache (32-byte lines)
// Revision : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dm_cache #(
  parameter int S_INDEX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [3:0]    mem_byte_enable,
  input  logic [31:0]   mem_address,
  input  logic [31:0]   mem_wdata,
  output logic [31:0]   mem_rdata,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [31:0]   pmem_address,
  output logic [255:0]  pmem_wdata,
  input  logic [255:0]  pmem_rdata,
  input  logic          pmem_resp
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SETS-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [255:0]       data_q [SETS];

  logic [TAG_W-1:0]   w_tag;
  logic [S_INDEX-1:0] w_idx;
  logic [7:0]         w_bit_off;
  logic               w_hit;
  logic [255:0]       w_line;
  logic [31:0]        w_cur_word;
  logic [31:0]        w_merged_word;
  logic [255:0]       w_line_wr;
  logic               w_hit_wr_en;
  logic               w_fill_en;
  logic               w_wb_done;
  logic               w_unused;

  assign w_tag      = mem_address[31:5+S_INDEX];
  assign w_idx      = mem_address[4+S_INDEX:5];
  assign w_bit_off  = {mem_address[4:2], 5'b0};
  assign w_line     = data_q[w_idx];
  assign w_cur_word = w_line[w_bit_off +: 32];
  assign w_hit      = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_unused   = ^mem_address[1:0];

  always_comb begin
    w_merged_word = w_cur_word;
    for (int i = 0; i < 4; i++) begin
      if (mem_byte_enable[i]) begin
        w_merged_word[8*i +: 8] = mem_wdata[8*i +: 8];
      end
    end
    w_line_wr = w_line;
    w_line_wr[w_bit_off +: 32] = w_merged_word;
  end

  // Outputs depend only on state and the held CPU request, never on pmem_*.
  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = 32'h0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'h0;
    pmem_wdata   = 256'h0;
    w_hit_wr_en  = 1'b0;
    w_fill_en    = 1'b0;
    w_wb_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (w_hit) begin
          mem_resp    = 1'b1;
          mem_rdata   = w_cur_word;
          w_hit_wr_en = mem_write;
          state_d     = IDLE;
        end else if (valid_q[w_idx] && dirty_q[w_idx]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[w_idx], w_idx, 5'b0};
        pmem_wdata   = w_line;
        if (pmem_resp) begin
          w_wb_done = 1'b1;
          state_d   = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[31:5], 5'b0};
        if (pmem_resp) begin
          w_fill_en = 1'b1;
          state_d   = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_hit_wr_en) begin
        dirty_q[w_idx] <= 1'b1;
      end
      if (w_wb_done) begin
        dirty_q[w_idx] <= 1'b0;
      end
      if (w_fill_en) begin
        valid_q[w_idx] <= 1'b1;
        dirty_q[w_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; a fill cannot fire while in reset.
  always_ff @(posedge clk) begin
    if (w_fill_en) begin
      data_q[w_idx] <= pmem_rdata;
      tag_q[w_idx]  <= w_tag;
    end else if (w_hit_wr_en) begin
      data_q[w_idx] <= w_line_wr;
    end
  end

endmodule

`default_nettype wire
